// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with zero-register, optional write bypass and clear sweep.
module regfile_param #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NREAD = 2,
    parameter int BYPASS = 1,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [AW-1:0]      rd,
    input  logic [XLEN-1:0]    din,
    input  logic [NREAD*AW-1:0] raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic               clear_req,
    output logic               ready
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [XLEN-1:0] regs [NREG];
    logic last, wr_ok;
    assign last = cnt == AW'(NREG - 1);
    assign ready = state == RUN;
    assign wr_ok = state == RUN && wen && !clear_req && {1'b0, rd} < (AW + 1)'(NREG)
                   && !(ZERO_REG != 0 && rd == '0);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (state == CLEAR) begin
            state_n = (last && !clear_req) ? RUN : CLEAR;
            cnt_n = (last || clear_req) ? '0 : cnt + AW'(1);
        end else if (clear_req) begin
            state_n = CLEAR;
            cnt_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // Storage has no reset of its own; the sweep defines it before RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) regs[cnt] <= '0;
            else if (wr_ok) regs[rd] <= din;
        end
    end
    for (genvar g = 0; g < NREAD; g++) begin : rp
        logic [AW-1:0] a;
        assign a = raddr[g*AW +: AW];
        assign rdata[g*XLEN +: XLEN] =
            (state != RUN || {1'b0, a} >= (AW + 1)'(NREG) || (ZERO_REG != 0 && a == '0)) ? '0 :
            (BYPASS != 0 && wen && a == rd) ? din : regs[a];
    end
endmodule
